// File: rtl/charram_dram_seq.sv
// charram_dram_seq
// Timing sequencer for the 4416-based character RAM (16K x 4, 8-bit row /
// 6-bit column multiplexed address). Runs a fixed two-slot loop: a pixel
// fetch slot (always a read) followed by a CPU slot. Each slot is four
// phases p0..p3, advanced by i_CEN. All outputs are registered.
//
// Optional feature macro: CHARRAM_SEQ_REFRESH_EN
//   Defined   - an idle CPU slot performs a RAS-only refresh driven by an
//               8-bit wrapping row counter.
//   Undefined - an idle CPU slot keeps every strobe high.
module charram_dram_seq (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_CEN,
    input  logic [13:0] i_PX_ADDR,
    output logic [3:0]  o_PX_DATA,
    output logic        o_PX_VALID,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_RW,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_DRAM_ADDR,
    output logic        o_DRAM_RAS_n,
    output logic        o_DRAM_CAS_n,
    output logic        o_DRAM_RD_n,
    output logic        o_DRAM_WR_n,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT
);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    // Access captured at p0; the row is not kept because o_DRAM_ADDR
    // already holds it through p1.
    typedef struct packed {
        logic       act;    // full RAS/CAS cycle with a RD or WR strobe
        logic       cpu;    // 1 = CPU slot, 0 = pixel slot
        logic       rd;     // 1 = read, 0 = write
`ifdef CHARRAM_SEQ_REFRESH_EN
        logic       rfsh;   // RAS-only refresh of the counter row
`endif
        logic [5:0] col;
        logic [3:0] din;
    } acc_t;

    phase_t     phase;
    phase_t     phase_nx;
    logic       slot;
    logic       slot_nx;
    logic       acked;
    acc_t       acc;
    acc_t       sel;
    logic [7:0] sel_row;
    logic       rd_pend;      // RD_n was low last cycle: DRAM data valid now
    logic       rd_pend_cpu;  // the pending read belongs to the CPU slot
    logic       ack_set;
`ifdef CHARRAM_SEQ_REFRESH_EN
    logic [7:0] rfsh_cnt;
`endif

    // Next phase/slot and the access that p0 would select right now.
    always_comb begin
        phase_nx = i_CEN ? phase_t'(phase + 2'd1) : phase;
        slot_nx  = (i_CEN && (phase == P3)) ? ~slot : slot;
        sel      = '0;
        sel_row  = '0;
        sel.cpu  = slot_nx;
        if (!slot_nx) begin
            sel.act = 1'b1;
            sel.rd  = 1'b1;
            sel.col = i_PX_ADDR[13:8];
            sel_row = i_PX_ADDR[7:0];
        end else if (i_CPU_REQ && !acked) begin
            sel.act = 1'b1;
            sel.rd  = i_CPU_RW;
            sel.col = i_CPU_ADDR[13:8];
            sel.din = i_CPU_DIN;
            sel_row = i_CPU_ADDR[7:0];
        end else begin
`ifdef CHARRAM_SEQ_REFRESH_EN
            sel.rfsh = 1'b1;
            sel_row  = rfsh_cnt;
`else
            sel_row  = i_CPU_ADDR[7:0];
`endif
        end
    end

    // A CPU access completes one cycle after WR_n low, or when read data lands.
    assign ack_set = (rd_pend && rd_pend_cpu) || !o_DRAM_WR_n;

    // Phase sequencer with registered DRAM strobes and requester handshakes.
    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            phase        <= P0;
            slot         <= 1'b0;
            acked        <= 1'b0;
            acc          <= '0;
            rd_pend      <= 1'b0;
            rd_pend_cpu  <= 1'b0;
            o_DRAM_RAS_n <= 1'b1;
            o_DRAM_CAS_n <= 1'b1;
            o_DRAM_RD_n  <= 1'b1;
            o_DRAM_WR_n  <= 1'b1;
            o_DRAM_ADDR  <= '0;
            o_DRAM_DIN   <= '0;
            o_PX_DATA    <= '0;
            o_PX_VALID   <= 1'b0;
            o_CPU_DOUT   <= '0;
            o_CPU_ACK    <= 1'b0;
`ifdef CHARRAM_SEQ_REFRESH_EN
            rfsh_cnt     <= '0;
`endif
        end else begin
            phase <= phase_nx;
            slot  <= slot_nx;

            // RD/WR pulses last exactly one MCLK, independent of i_CEN.
            o_DRAM_RD_n <= 1'b1;
            o_DRAM_WR_n <= 1'b1;
            o_PX_VALID  <= 1'b0;
            o_CPU_ACK   <= 1'b0;

            rd_pend     <= !o_DRAM_RD_n;
            rd_pend_cpu <= acc.cpu;

            // While in p0 the selection tracks its inputs; the value seen on
            // the edge leaving p0 is the one used for the slot.
            if (phase == P0)
                acc <= sel;
            if ((phase == P0) || (phase_nx == P0))
                o_DRAM_ADDR <= sel_row;

            if (i_CEN) begin
                case (phase)
                    P0: begin
`ifdef CHARRAM_SEQ_REFRESH_EN
                        o_DRAM_RAS_n <= !(sel.act || sel.rfsh);
`else
                        o_DRAM_RAS_n <= !sel.act;
`endif
                    end
                    P1: begin
                        if (acc.act) begin
                            o_DRAM_ADDR  <= {1'b0, acc.col, 1'b0};
                            o_DRAM_CAS_n <= 1'b0;
                        end
                    end
                    P2: begin
                        if (acc.act) begin
                            if (acc.rd) begin
                                o_DRAM_RD_n <= 1'b0;
                            end else begin
                                o_DRAM_WR_n <= 1'b0;
                                o_DRAM_DIN  <= acc.din;
                            end
                        end
                    end
                    P3: begin
                        o_DRAM_RAS_n <= 1'b1;
                        o_DRAM_CAS_n <= 1'b1;
`ifdef CHARRAM_SEQ_REFRESH_EN
                        if (acc.rfsh)
                            rfsh_cnt <= rfsh_cnt + 8'd1;
`endif
                    end
                    default: ;
                endcase
            end

            // Route read data to whichever slot issued the read.
            if (rd_pend) begin
                if (rd_pend_cpu) begin
                    o_CPU_DOUT <= i_DRAM_DOUT;
                    o_CPU_ACK  <= 1'b1;
                end else begin
                    o_PX_DATA  <= i_DRAM_DOUT;
                    o_PX_VALID <= 1'b1;
                end
            end
            if (!o_DRAM_WR_n)
                o_CPU_ACK <= 1'b1;

            // A dropped request always re-arms; otherwise latch completion.
            if (!i_CPU_REQ)
                acked <= 1'b0;
            else if (ack_set)
                acked <= 1'b1;
        end
    end

endmodule
